// File: rtl/cache_refill_if.sv
// Bundle of the miss, memory-bus and way-write signals of cache_refill_ctrl.
// The master modport is the refill engine; the slave modport is its surroundings.
interface cache_refill_if #(
   parameter int INDEX_WIDTH = 7,
   parameter int TAG_WIDTH   = 20,
   parameter int LINE_WIDTH  = 128,
   parameter int BEAT_WIDTH  = 32
);
   localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;
   localparam int BCNT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int ADDR_WIDTH = TAG_WIDTH + INDEX_WIDTH + $clog2(LINE_WIDTH / 8);

   logic                          i_cr_miss_vld;
   logic                          o_cr_miss_rdy;
   logic [INDEX_WIDTH-1:0]        i_cr_miss_idx;
   logic [TAG_WIDTH-1:0]          i_cr_miss_tag;
   logic [BCNT_WIDTH-1:0]         i_cr_miss_woff;
   logic                          o_cr_mem_req_vld;
   logic                          i_cr_mem_req_rdy;
   logic [ADDR_WIDTH-1:0]         o_cr_mem_addr;
   logic                          i_cr_mem_rsp_vld;
   logic                          o_cr_mem_rsp_rdy;
   logic [BEAT_WIDTH-1:0]         i_cr_mem_rsp_data;
   logic                          i_cr_mem_rsp_err;
   logic                          o_cr_wren;
   logic [INDEX_WIDTH-1:0]        o_cr_widx;
   logic [TAG_WIDTH+LINE_WIDTH-1:0] o_cr_wdata;
   logic                          o_cr_done;
   logic                          o_cr_err;
   logic                          o_cr_fwd_vld;
   logic [BEAT_WIDTH-1:0]         o_cr_fwd_data;

   modport master (
      input  i_cr_miss_vld, i_cr_miss_idx, i_cr_miss_tag, i_cr_miss_woff,
      input  i_cr_mem_req_rdy, i_cr_mem_rsp_vld, i_cr_mem_rsp_data, i_cr_mem_rsp_err,
      output o_cr_miss_rdy, o_cr_mem_req_vld, o_cr_mem_addr, o_cr_mem_rsp_rdy,
      output o_cr_wren, o_cr_widx, o_cr_wdata, o_cr_done, o_cr_err,
      output o_cr_fwd_vld, o_cr_fwd_data
   );

   modport slave (
      output i_cr_miss_vld, i_cr_miss_idx, i_cr_miss_tag, i_cr_miss_woff,
      output i_cr_mem_req_rdy, i_cr_mem_rsp_vld, i_cr_mem_rsp_data, i_cr_mem_rsp_err,
      input  o_cr_miss_rdy, o_cr_mem_req_vld, o_cr_mem_addr, o_cr_mem_rsp_rdy,
      input  o_cr_wren, o_cr_widx, o_cr_wdata, o_cr_done, o_cr_err,
      input  o_cr_fwd_vld, o_cr_fwd_data
   );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache line refill engine: one miss at a time, line read, beat collection, single way write.
// Define CACHE_REFILL_CWF_EN for critical-word-first requests and forwarding of the first beat.
module cache_refill_ctrl #(
   parameter int INDEX_WIDTH = 7,
   parameter int TAG_WIDTH   = 20,
   parameter int LINE_WIDTH  = 128,
   parameter int BEAT_WIDTH  = 32
) (
   input logic            clk,
   input logic            rst_n,
   cache_refill_if.master bus
);
   localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;
   localparam int BCNT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int OFF_WIDTH  = $clog2(LINE_WIDTH / 8);
   localparam int ADDR_WIDTH = TAG_WIDTH + INDEX_WIDTH + OFF_WIDTH;
   localparam logic [BCNT_WIDTH-1:0] LAST_BEAT = BCNT_WIDTH'(BEATS - 1);

   typedef enum logic [2:0] {IDLE, REQ, FILL, WRITE, FAIL} state_t;

   state_t                  state;
   logic                    miss_rdy;
   logic                    req_vld;
   logic                    rsp_rdy;
   logic                    wren;
   logic                    done;
   logic                    err;
   logic                    err_seen;
   logic [INDEX_WIDTH-1:0]  idx_q;
   logic [TAG_WIDTH-1:0]    tag_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [LINE_WIDTH-1:0]   line_q;
   logic [BCNT_WIDTH-1:0]   bcnt;
   logic [BCNT_WIDTH-1:0]   bcnt_next;
   logic [BCNT_WIDTH-1:0]   beat_num;
   logic [BCNT_WIDTH-1:0]   bcnt_start;
   logic [OFF_WIDTH-1:0]    addr_low;
   logic                    beat_err;

`ifdef CACHE_REFILL_CWF_EN
   // Memory wraps the burst from the requested word, so the buffer slot starts there too.
   localparam int BYTE_SHIFT = $clog2(BEAT_WIDTH / 8);
   logic fwd_vld;
   assign bcnt_start = bus.i_cr_miss_woff;
   assign addr_low   = OFF_WIDTH'(bus.i_cr_miss_woff) << BYTE_SHIFT;
   assign fwd_vld    = (state == FILL) && bus.i_cr_mem_rsp_vld && (beat_num == '0);
   assign bus.o_cr_fwd_vld  = fwd_vld;
   assign bus.o_cr_fwd_data = fwd_vld ? bus.i_cr_mem_rsp_data : '0;
`else
   assign bcnt_start = '0;
   assign addr_low   = '0;
   assign bus.o_cr_fwd_vld  = 1'b0;
   assign bus.o_cr_fwd_data = '0;
`endif

   assign bcnt_next = (bcnt == LAST_BEAT) ? '0 : bcnt + 1'b1;
   assign beat_err  = err_seen | bus.i_cr_mem_rsp_err;

   // Single FSM; every handshake and write-port output is a register updated on the state transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         miss_rdy <= 1'b1;
         req_vld  <= 1'b0;
         rsp_rdy  <= 1'b0;
         wren     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         err_seen <= 1'b0;
         idx_q    <= '0;
         tag_q    <= '0;
         addr_q   <= '0;
         line_q   <= '0;
         bcnt     <= '0;
         beat_num <= '0;
      end else begin
         wren <= 1'b0;
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.i_cr_miss_vld) begin
                  idx_q    <= bus.i_cr_miss_idx;
                  tag_q    <= bus.i_cr_miss_tag;
                  addr_q   <= {bus.i_cr_miss_tag, bus.i_cr_miss_idx, addr_low};
                  bcnt     <= bcnt_start;
                  beat_num <= '0;
                  err_seen <= 1'b0;
                  miss_rdy <= 1'b0;
                  req_vld  <= 1'b1;
                  state    <= REQ;
               end
            end
            REQ: begin
               if (bus.i_cr_mem_req_rdy) begin
                  req_vld <= 1'b0;
                  rsp_rdy <= 1'b1;
                  state   <= FILL;
               end
            end
            FILL: begin
               if (bus.i_cr_mem_rsp_vld) begin
                  line_q[bcnt*BEAT_WIDTH +: BEAT_WIDTH] <= bus.i_cr_mem_rsp_data;
                  bcnt     <= bcnt_next;
                  beat_num <= beat_num + 1'b1;
                  err_seen <= beat_err;
                  // The last beat's own error decides the outcome as well as any earlier one.
                  if (beat_num == LAST_BEAT) begin
                     rsp_rdy <= 1'b0;
                     done    <= 1'b1;
                     if (beat_err) begin
                        err   <= 1'b1;
                        state <= FAIL;
                     end else begin
                        wren  <= 1'b1;
                        state <= WRITE;
                     end
                  end
               end
            end
            WRITE, FAIL: begin
               miss_rdy <= 1'b1;
               state    <= IDLE;
            end
            default: begin
               miss_rdy <= 1'b1;
               req_vld  <= 1'b0;
               rsp_rdy  <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   assign bus.o_cr_miss_rdy    = miss_rdy;
   assign bus.o_cr_mem_req_vld = req_vld;
   assign bus.o_cr_mem_addr    = addr_q;
   assign bus.o_cr_mem_rsp_rdy = rsp_rdy;
   assign bus.o_cr_wren        = wren;
   assign bus.o_cr_widx        = idx_q;
   assign bus.o_cr_wdata       = {tag_q, line_q};
   assign bus.o_cr_done        = done;
   assign bus.o_cr_err         = err;
endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Refill engine on the write side of a cache way array. It accepts one miss (index, tag, word offset) at a time and issues a line read to the memory bus. It collects the returned beats into a line buffer, then drives a single write (enable, index, {tag, line}) into the way storage. A done/error pulse back to the miss requester closes each refill.

Parameters:
INDEX_WIDTH, 7, set index width; matches the way's index width.
TAG_WIDTH, 20, tag bits stored per line.
LINE_WIDTH, 128, data bits per line.
BEAT_WIDTH, 32, memory response beat width; LINE_WIDTH must be an integer multiple.
BEATS, LINE_WIDTH/BEAT_WIDTH, beats per line (derived).
BCNT_WIDTH, $clog2(BEATS), beat counter / word offset width (derived).
ADDR_WIDTH, TAG_WIDTH+INDEX_WIDTH+$clog2(LINE_WIDTH/8), byte address width (derived).

Ports:
clk  input  1  clock.
rst_n  input  1  asynchronous active-low reset.
i_cr_miss_vld  input  1  miss request valid.
o_cr_miss_rdy  output  1  high only in IDLE.
i_cr_miss_idx  input  INDEX_WIDTH  missing set index.
i_cr_miss_tag  input  TAG_WIDTH  missing tag.
i_cr_miss_woff  input  BCNT_WIDTH  requested word within the line.
o_cr_mem_req_vld  output  1  memory line read request valid.
i_cr_mem_req_rdy  input  1  memory accepts request.
o_cr_mem_addr  output  ADDR_WIDTH  request byte address.
i_cr_mem_rsp_vld  input  1  response beat valid.
o_cr_mem_rsp_rdy  output  1  high only in FILL.
i_cr_mem_rsp_data  input  BEAT_WIDTH  beat data.
i_cr_mem_rsp_err  input  1  bus error on this beat.
o_cr_wren  output  1  way write enable, one-cycle pulse.
o_cr_widx  output  INDEX_WIDTH  way write index.
o_cr_wdata  output  TAG_WIDTH+LINE_WIDTH  {tag, line}; feeds the way's write data (way DATA_WIDTH = this width + 1).
o_cr_done  output  1  one-cycle refill-complete pulse.
o_cr_err  output  1  qualifies o_cr_done: refill failed, no write.
o_cr_fwd_vld  output  1  critical word forward valid (optional feature).
o_cr_fwd_data  output  BEAT_WIDTH  critical word (optional feature).

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0 except o_cr_miss_rdy=1. Line buffer, beat counter, and error flag cleared. Reset mid-refill abandons it; no write is issued.
- FSM states: IDLE, REQ, FILL, WRITE, FAIL.
- IDLE: on miss_vld & miss_rdy, latch idx/tag/woff, then go to REQ next cycle.
- REQ: mem_req_vld=1. Address is {tag, idx, low bits}: low bits are 0 (line aligned), or woff*BEAT_WIDTH/8 with the optional feature. Address and valid are held stable until req_rdy. On the handshake, go to FILL.
- FILL: rsp_rdy=1. Each rsp_vld beat is written to buffer slice [bcnt*BEAT_WIDTH +: BEAT_WIDTH]. bcnt increments modulo BEATS. A rsp_err on any beat sets a sticky error flag. Exactly BEATS beats are accepted. On the last beat, go to WRITE if there is no error (including that beat), else to FAIL.
- WRITE (1 cycle): o_cr_wren=1, o_cr_widx=latched idx, o_cr_wdata={tag, buffer}, o_cr_done=1, o_cr_err=0. Then go to IDLE.
- FAIL (1 cycle): o_cr_done=1, o_cr_err=1, o_cr_wren=0. Then go to IDLE.
- Latency: minimum miss accept to write is 1 (REQ) + BEATS (FILL) cycles; wren is asserted in the following cycle.
- miss_rdy is 0 from accept until the cycle after done. New misses are never accepted in WRITE/FAIL.
- rsp_vld outside FILL is a protocol violation. It is ignored, and rsp_rdy=0 there.
- o_cr_widx/o_cr_wdata are don't-care when wren=0 but must hold latched values (no X).

Optional Feature:
Macro: CACHE_REFILL_CWF_EN (critical word first).
- Enabled: the request address carries woff. Memory returns beats wrapping from woff, so bcnt starts at the latched woff and wraps modulo BEATS. In the cycle of the first accepted beat, o_cr_fwd_vld=1 and o_cr_fwd_data=that beat, even if it errors.
- Disabled: request is line aligned, bcnt starts at 0, woff is ignored, and o_cr_fwd_vld/o_cr_fwd_data are tied 0.

Test Plan:
- Basic refill: miss idx=5, tag=0xABCDE, woff=0; req_rdy immediate; beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles -> addr={0xABCDE,5,4'h0}, wren pulse with widx=5, wdata={0xABCDE, 0x44444444_33333333_22222222_11111111}, done=1, err=0.
- Backpressure/gaps: req_rdy low 3 cycles, rsp_vld idle 2 cycles between beats -> req_vld and addr held stable; exactly 4 beats captured; single wren.
- Error: rsp_err on beat 2 of 4 -> all 4 beats consumed, wren never asserted, done=1 with err=1 in one cycle, miss_rdy=1 the next cycle.
- Back-to-back: second miss (idx=127, tag=0) presented during FILL -> not accepted until IDLE; second refill writes widx=127 with no corruption from the first line.
- Reset mid-FILL after beat 1 -> outputs 0, miss_rdy=1; no wren; a fresh refill after reset is correct.
- CWF (macro on): woff=2 -> addr low bits 4'h8; beats B0..B3 land in slots 2,3,0,1; fwd_vld=1 with fwd_data=B0 on the first beat only.
